sum_accumulator: RTL and testbench

Downstream consumer of the full-adder stage. Takes each 8-bit sum plus its carry-out as one 9-bit beat over a valid/ready handshake. Accumulates a programmed number of beats into a wide register, then presents the total with a sticky overflow flag. Sits between the adder output and the result readout mux of the Tiny Tapeout top level.

---
 rtl/sum_acc_pkg.sv | 20 ++
 rtl/sum_accumulator.sv | 127 ++++++++++++
 tb/tb_sum_accumulator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared types and helpers for the sum accumulator.
// Holds the FSM state encoding, the beat width and the beat packing helper.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // One beat is the adder carry-out on top of the 8-bit sum.
    localparam int BEAT_W = 9;

    // Packs a sum/carry pair into a single unsigned beat value (0..0x1FF).
    // The accumulator zero-extends this to its own width.
    function automatic logic [BEAT_W-1:0] pack_beat(input logic carry, input logic [7:0] sum);
        return {carry, sum};
    endfunction

endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a programmed number of 9-bit adder beats into a wide
// register and presents the total with a sticky overflow flag.
// Optional build macro SUM_ACC_SAT_EN: when defined the accumulator clamps to
// all-ones on overflow; when undefined it wraps modulo 2^ACC_W.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sum,
    input  logic             in_carry,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    state_t           state_reg;
    state_t           state_next;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] len_reg;
    logic             ovf_reg;

    logic [BEAT_W-1:0] beat;
    logic [ACC_W:0]    add_full;
    logic              add_carry;
    logic [ACC_W-1:0]  acc_sum;
    logic              xfer;
    logic              last_beat;

    assign beat      = pack_beat(in_carry, in_sum);
    // One extra bit on the adder catches the carry out of the top bit.
    assign add_full  = {1'b0, acc_reg} + {{(ACC_W + 1 - BEAT_W){1'b0}}, beat};
    assign add_carry = add_full[ACC_W];

`ifdef SUM_ACC_SAT_EN
    // Saturating mode: once clamped, further adds carry again and stay clamped.
    assign acc_sum = add_carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign acc_sum = add_full[ACC_W-1:0];
`endif

    assign xfer      = in_valid && in_ready;
    // len_reg is never zero in RUN, so len_reg-1 cannot underflow here.
    assign last_beat = (cnt_reg == (len_reg - CNT_W'(1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? HOLD : RUN;
                end
            end
            RUN: begin
                if (xfer && last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, never of the handshakes.
    always_comb begin
        in_ready  = (state_reg == RUN);
        acc_valid = (state_reg == HOLD);
        acc_out   = acc_reg;
        ovf       = ovf_reg;
    end

    // Datapath: clear on accepted start, add on each transfer, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            len_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg <= '0;
                        cnt_reg <= '0;
                        len_reg <= len;
                        ovf_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_reg <= acc_sum;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (add_carry) begin
                            ovf_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed and randomized runs of sum_accumulator checked
// against an arithmetic model of the running total and overflow flag.
// Honours SUM_ACC_SAT_EN the same way the design does.
module tb_sum_accumulator;

    localparam int ACC_W   = 10;
    localparam int CNT_W   = 4;
    localparam int ACC_MOD = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len_i = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_sum = '0;
    logic             in_carry = 1'b0;
    logic             acc_valid;
    logic             acc_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    sum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer running sum with overflow detection.
    function automatic void model(input int beats[$], output int total, output bit of);
        int s;
        total = 0;
        of    = 1'b0;
        foreach (beats[i]) begin
            s = total + beats[i];
            if (s >= ACC_MOD) begin
                of = 1'b1;
`ifdef SUM_ACC_SAT_EN
                total = ACC_MOD - 1;
`else
                total = s - ACC_MOD;
`endif
            end else begin
                total = s;
            end
        end
    endfunction

    // One full run: start, beats with gaps[i] bubble cycles before beat i
    // (start pulsed during bubbles), hold_cycles of backpressure, then drain
    // with a start in the same cycle as the handshake (must be ignored).
    task automatic do_run(input string tag, input int beats[$], input int gaps[$], input int hold_cycles);
        int total;
        bit of;
        int n;
        logic [31:0] b;
        n = beats.size();
        model(beats, total, of);
        start = 1'b1;
        len_i = CNT_W'(n);
        tick();
        start = 1'b0;
        foreach (beats[i]) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0;
                start    = 1'b1;
                len_i    = CNT_W'($urandom_range(0, 15));
                check({tag, "_ready_bubble"}, 32'(in_ready), 32'd1);
                tick();
            end
            start    = 1'b0;
            b        = beats[i];
            in_valid = 1'b1;
            in_carry = b[8];
            in_sum   = b[7:0];
            check({tag, "_ready_beat"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
        end
        check({tag, "_valid"}, 32'(acc_valid), 32'd1);
        check({tag, "_ready_hold"}, 32'(in_ready), 32'd0);
        check({tag, "_acc"}, 32'(acc_out), 32'(total));
        check({tag, "_ovf"}, 32'(ovf), 32'(of));
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sum   = 8'($urandom_range(0, 255));
            tick();
            check({tag, "_bp_valid"}, 32'(acc_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_acc"}, 32'(acc_out), 32'(total));
        end
        in_valid  = 1'b0;
        acc_ready = 1'b1;
        start     = 1'b1;
        len_i     = CNT_W'(1);
        tick();
        acc_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_idle_valid"}, 32'(acc_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_idle_acc"}, 32'(acc_out), 32'(total));
        check({tag, "_idle_ovf"}, 32'(ovf), 32'(of));
        $display("run %s len=%0d total=%0h ovf=%0d", tag, n, total, of);
    endtask

    initial begin
        int bq[$];
        int gq[$];
        int n;

        // Reset state.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_acc_valid", 32'(acc_valid), 32'd0);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        // Basic run, back-to-back beats.
        bq = {32'h010, 32'h1FF, 32'h001};
        gq = {0, 0, 0};
        do_run("basic", bq, gq, 0);

        // Zero-length run.
        bq = {};
        gq = {};
        do_run("zero_len", bq, gq, 0);

        // Overflow with three max beats.
        bq = {32'h1FF, 32'h1FF, 32'h1FF};
        gq = {0, 0, 0};
        do_run("overflow", bq, gq, 0);

        // Bubbles (valid pattern 1,0,0,1) with start pulsed mid-run; ovf must be cleared.
        bq = {32'h005, 32'h007};
        gq = {0, 2};
        do_run("bubbles", bq, gq, 0);

        // Backpressure in HOLD.
        bq = {32'h0AB, 32'h100};
        gq = {0, 0};
        do_run("backpressure", bq, gq, 5);

        // Reset mid-run after one of three beats.
        start = 1'b1;
        len_i = CNT_W'(3);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_carry = 1'b1;
        in_sum   = 8'h33;
        tick();
        in_valid = 1'b0;
        check("mid_partial_acc", 32'(acc_out), 32'h133);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_acc_valid", 32'(acc_valid), 32'd0);
        check("mid_rst_acc_out", 32'(acc_out), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(in_ready), 32'd0);
        bq = {32'h020};
        gq = {0};
        do_run("post_rst", bq, gq, 0);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            bq = {};
            gq = {};
            n  = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) begin
                bq.push_back(int'($urandom_range(0, 511)));
                gq.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            do_run($sformatf("rand%0d", r), bq, gq, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
